// File: rtl/tape_input_bridge_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte/frame-error pulses.
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  rx_state_e     state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;

  // Synchroniser and edge history idle high so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else cnt_d = cnt_q + 1'b1;
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else cnt_d = cnt_q + 1'b1;
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (sync2_q) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      RX_WAIT_HIGH: if (sync2_q) state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
endmodule

// File: rtl/tape_input_bridge.sv
// UART-to-tape-reader bridge: received codes are buffered and presented with a 4-phase val/rdy handshake.
module tape_input_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int SETUP_CYCLES = 3
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        uart_rxd,
  input  logic                        dev_input_rdy,
  output logic                        dev_input_val,
  output logic [4:0]                  dev_input_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        err_framing,
  output logic                        err_overrun,
  input  logic                        err_clear
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int SW   = $clog2(SETUP_CYCLES + 1);

  typedef enum logic [1:0] {HS_IDLE, HS_SETUP, HS_ASSERT, HS_RELEASE} hs_state_e;

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;
  logic       rx_byte_unused;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i        (clk),
    .rst_n_i      (resetn),
    .rxd_i        (uart_rxd),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr)
  );
  // Only five-bit tape codes exist; the upper bits of the byte carry nothing.
  assign rx_byte_unused = ^rx_byte[7:5];

  logic [4:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  hs_state_e       hs_q, hs_d;
  logic [SW-1:0]   sc_q, sc_d;
  logic            val_q, val_d;
  logic [4:0]      data_q, data_d;
  logic            ferr_q, oerr_q;
  logic            full, pop, push;

  assign full = (count_q == CNTW'(FIFO_DEPTH));
  assign pop  = (hs_q == HS_IDLE) && dev_input_rdy && (count_q != '0);
  assign push = rx_valid && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNTW'(1);
    else if (!push && pop) count_d = count_q - CNTW'(1);
  end

  always_comb begin
    hs_d   = hs_q;
    sc_d   = sc_q;
    val_d  = val_q;
    data_d = data_q;
    case (hs_q)
      HS_IDLE: begin
        val_d = 1'b0;
        if (pop) begin
          data_d = mem_q[rd_ptr_q];
          sc_d   = '0;
          hs_d   = HS_SETUP;
        end
      end
      HS_SETUP: begin
        if (sc_q == SW'(SETUP_CYCLES - 1)) begin
          val_d = 1'b1;
          hs_d  = HS_ASSERT;
        end else sc_d = sc_q + 1'b1;
      end
      HS_ASSERT: begin
        if (!dev_input_rdy) begin
          val_d = 1'b0;
          hs_d  = HS_RELEASE;
        end
      end
      HS_RELEASE: if (dev_input_rdy) hs_d = HS_IDLE;
      default: hs_d = HS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_byte[4:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hs_q     <= HS_IDLE;
      sc_q     <= '0;
      val_q    <= 1'b0;
      data_q   <= '0;
      ferr_q   <= 1'b0;
      oerr_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      hs_q    <= hs_d;
      sc_q    <= sc_d;
      val_q   <= val_d;
      data_q  <= data_d;
      // A new error in the same cycle as a clear keeps the flag set.
      if (rx_ferr)        ferr_q <= 1'b1;
      else if (err_clear) ferr_q <= 1'b0;
      if (rx_valid && !push) oerr_q <= 1'b1;
      else if (err_clear)    oerr_q <= 1'b0;
    end
  end

  assign dev_input_val  = val_q;
  assign dev_input_data = data_q;
  assign fifo_count     = count_q;
  assign err_framing    = ferr_q;
  assign err_overrun    = oerr_q;
endmodule
